// File: rtl/mult_hilo_seq.sv
// Multiply sequencer and HI/LO register file placed in front of the ALU.
// It runs the ALU through a MULT-LO phase and then a MULT-HI phase, and commits HI/LO atomically.
module mult_hilo_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        n_flag,
    output logic        z_flag,
    output logic        busy,
    output logic        done,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    input  logic        alu_n,
    input  logic        alu_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO_PH = 2'd1,
        HI_PH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] FUNC_ADDU    = 6'b100001;
    localparam logic [5:0] FUNC_MULT_LO = 6'b011001;
    localparam logic [5:0] FUNC_MULT_HI = 6'b011010;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] opa_r;
    logic [31:0] opb_r;
    logic [31:0] lo_tmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ALU drive is decoded from the state register only, so it is stable from the clock edge.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_func  = FUNC_ADDU;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LO_PH;
                end
            end
            LO_PH: begin
                busy      = 1'b1;
                alu_func  = FUNC_MULT_LO;
                alu_a     = opa_r;
                alu_b     = opb_r;
                state_nxt = HI_PH;
            end
            HI_PH: begin
                busy      = 1'b1;
                alu_func  = FUNC_MULT_HI;
                alu_a     = opa_r;
                alu_b     = opb_r;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r <= '0;
            opb_r <= '0;
        end else if (state == IDLE && start) begin
            opa_r <= op_a;
            opb_r <= op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_tmp <= '0;
        end else if (state == LO_PH) begin
            lo_tmp <= alu_y;
        end
    end

    // The multiply commit takes priority over MTHI/MTLO on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == HI_PH) begin
            hi <= alu_y;
            lo <= lo_tmp;
        end else begin
            if (mthi) begin
                hi <= wdata;
            end
            if (mtlo) begin
                lo <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (state == HI_PH) begin
            n_flag <= alu_n;
            z_flag <= alu_z;
        end
    end

    assign rdata = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Bench for mult_hilo_seq: behavioural ALU model, directed steps, and a result scoreboard.
// It pops expected HI/LO/flag values on every done pulse.
module tb_mult_hilo_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_sel;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        n_flag;
    logic        z_flag;
    logic        busy;
    logic        done;
    logic [5:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_n;
    logic        alu_z;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_MLO  = 6'b011001;
    localparam logic [5:0] F_MHI  = 6'b011010;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        n;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   done_cnt;

    mult_hilo_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .rd_sel   (rd_sel),
        .rdata    (rdata),
        .hi       (hi),
        .lo       (lo),
        .n_flag   (n_flag),
        .z_flag   (z_flag),
        .busy     (busy),
        .done     (done),
        .alu_func (alu_func),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_n    (alu_n),
        .alu_z    (alu_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: signed 64-bit product, with flags taken from the full product.
    logic signed [63:0] prod;
    always_comb begin
        prod  = $signed(alu_a) * $signed(alu_b);
        alu_n = prod[63];
        alu_z = (prod == 64'sd0);
        case (alu_func)
            F_MLO:   alu_y = prod[31:0];
            F_MHI:   alu_y = prod[63:32];
            default: alu_y = alu_a + alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: each done pulse must match the oldest outstanding multiply.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            chk("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_n", 32'(n_flag), 32'(e.n));
                chk("sb_z", 32'(z_flag), 32'(e.z));
                chk("sb_rdata_hi", rdata, e.hi);
                chk("sb_busy_with_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. In mode 1, start is re-pulsed in cycles 1-3 and op_a changes in cycle 1.
    // In mode 2, mthi=0x55 is asserted in cycle 2.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic en, input logic ez, input int mode);
        int d0;
        exp_q.push_back('{hi: ehi, lo: elo, n: en, z: ez});
        d0    = done_cnt;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = (mode == 1);
        if (mode == 1) op_a = ~a;
        @(negedge clk);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_done", 32'(done), 32'd0);
        chk("c1_func", 32'(alu_func), 32'(F_MLO));
        chk("c1_alu_a", alu_a, a);
        chk("c1_alu_b", alu_b, b);
        tick();
        if (mode == 2) begin
            mthi  = 1'b1;
            wdata = 32'h55;
        end
        @(negedge clk);
        chk("c2_busy", 32'(busy), 32'd1);
        chk("c2_func", 32'(alu_func), 32'(F_MHI));
        chk("c2_alu_a", alu_a, a);
        tick();
        mthi = 1'b0;
        @(negedge clk);
        chk("c3_done", 32'(done), 32'd1);
        chk("c3_busy", 32'(busy), 32'd0);
        chk("c3_func", 32'(alu_func), 32'(F_ADDU));
        chk("c3_alu_a", alu_a, 32'd0);
        tick();
        start = 1'b0;
        op_a  = a;
        @(negedge clk);
        chk("c4_idle_busy", 32'(busy), 32'd0);
        chk("c4_idle_done", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        tick();
    endtask

    initial begin
        int d0;
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        wdata    = '0;
        rd_sel   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_n_flag", 32'(n_flag), 32'd0);
        chk("rst_z_flag", 32'(z_flag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_func", 32'(alu_func), 32'(F_ADDU));
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        rst_n = 1'b1;

        run_mult(32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0, 0);
        run_mult(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 0);
        run_mult(32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b1, 0);

        // MTLO: a read in the same cycle returns the old value, and the flags are untouched.
        rd_sel = 1'b0;
        mtlo   = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mtlo_same_cycle_rdata", rdata, 32'h0);
        tick();
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        chk("mtlo_rdata", rdata, 32'hDEAD_BEEF);
        chk("mtlo_z_kept", 32'(z_flag), 32'd1);
        chk("mtlo_n_kept", 32'(n_flag), 32'd0);
        chk("mtlo_hi_kept", hi, 32'h0);

        // MTHI and MTLO together write both registers.
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_0F0F;
        tick();
        mthi   = 1'b0;
        mtlo   = 1'b0;
        rd_sel = 1'b1;
        #1;
        chk("mtboth_hi", rdata, 32'hA5A5_0F0F);
        chk("mtboth_lo", lo, 32'hA5A5_0F0F);
        tick();

        run_mult(32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 1'b1, 1'b0, 1);
        run_mult(32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 1'b0, 2);
        run_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 0);

        // Reset during HI_PH aborts without done.
        d0    = done_cnt;
        op_a  = 32'd4;
        op_b  = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_func", 32'(alu_func), 32'(F_ADDU));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_still_zero", lo, 32'h0);

        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b0, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
